// File: rtl/m68k_region_decoder_if.sv
// 68000 bus and region-table configuration bundle for m68k_region_decoder.
// The master side is the CPU/boot logic; the slave side is the decoder itself.
interface m68k_region_decoder_if #(
  parameter int NREG = 24,
  parameter int AW   = 24,
  parameter int WS_W = 3
);
  logic            cfg_we;
  logic [4:0]      cfg_idx;
  logic [AW-1:0]   cfg_base;
  logic [4:0]      cfg_width;
  logic [WS_W-1:0] cfg_wait;
  logic            cfg_ext;
  logic            cfg_en;
  logic [AW-1:0]   cpu_a;
  logic            cpu_as_n;
  logic            ext_rdy;
  logic [NREG-1:0] cs;
  logic [4:0]      hit_idx;
  logic            dtack_n;
  logic            berr_n;

  modport master (
    output cfg_we, cfg_idx, cfg_base, cfg_width, cfg_wait, cfg_ext, cfg_en,
    output cpu_a, cpu_as_n, ext_rdy,
    input  cs, hit_idx, dtack_n, berr_n
  );

  modport slave (
    input  cfg_we, cfg_idx, cfg_base, cfg_width, cfg_wait, cfg_ext, cfg_en,
    input  cpu_a, cpu_as_n, ext_rdy,
    output cs, hit_idx, dtack_n, berr_n
  );
endinterface

// File: rtl/m68k_region_decoder.sv
// Table-driven 68000 chip-select decoder: NREG programmable windows, registered one-hot
// select, /DTACK after per-region wait states, /BERR on unmapped-address timeout.
module m68k_region_decoder #(
  parameter int NREG  = 24,
  parameter int AW    = 24,
  parameter int WS_W  = 3,
  parameter int TMO_W = 7
) (
  input logic                 clk,
  input logic                 reset_n,
  m68k_region_decoder_if.slave bus
);
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_DECODE = 3'd1,
    ST_WAIT   = 3'd2,
    ST_ACK    = 3'd3,
    ST_TMO    = 3'd4,
    ST_BERR   = 3'd5
  } state_e;

  localparam logic [5:0] NREG_L = 6'(NREG);

  // Bits at or above the programmed width must agree; width >= AW leaves no bits to compare.
  function automatic logic slot_match(input logic [AW-1:0] a, input logic [AW-1:0] b,
                                      input logic [4:0] w);
    logic [AW-1:0] diff;
    diff = a ^ b;
    slot_match = 1'b1;
    for (int j = 0; j < AW; j++) begin
      if ((j >= int'(w)) && diff[j]) slot_match = 1'b0;
    end
  endfunction

  logic [AW-1:0]   base_q  [NREG];
  logic [4:0]      width_q [NREG];
  logic [WS_W-1:0] wait_q  [NREG];
  logic [NREG-1:0] ext_q;
  logic [NREG-1:0] en_q;
  logic            cfg_ok_s;

  state_e          state_q, state_d;
  logic [NREG-1:0] cs_q, cs_d;
  logic [4:0]      hit_idx_q, hit_idx_d;
  logic            dtack_n_q, dtack_n_d;
  logic            berr_n_q, berr_n_d;
  logic [WS_W-1:0] wcnt_q, wcnt_d;
  logic            ext_lat_q, ext_lat_d;
  logic [TMO_W-1:0] tcnt_q, tcnt_d;
  logic [TMO_W-1:0] tcnt_inc_s;
  logic            hit_s;
  logic [4:0]      hit_k_s;

  assign cfg_ok_s = bus.cfg_we && ({1'b0, bus.cfg_idx} < NREG_L);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NREG; i++) begin
        base_q[i]  <= '0;
        width_q[i] <= 5'd0;
        wait_q[i]  <= '0;
      end
      ext_q <= '0;
      en_q  <= '0;
    end else if (cfg_ok_s) begin
      base_q[bus.cfg_idx]  <= bus.cfg_base;
      width_q[bus.cfg_idx] <= bus.cfg_width;
      wait_q[bus.cfg_idx]  <= bus.cfg_wait;
      ext_q[bus.cfg_idx]   <= bus.cfg_ext;
      en_q[bus.cfg_idx]    <= bus.cfg_en;
    end
  end

  // Scan from the top down so the lowest matching slot is the one left standing.
  always_comb begin
    hit_s   = 1'b0;
    hit_k_s = 5'd0;
    for (int i = NREG - 1; i >= 0; i--) begin
      if (en_q[i] && slot_match(bus.cpu_a, base_q[i], width_q[i])) begin
        hit_s   = 1'b1;
        hit_k_s = 5'(i);
      end
    end
  end

  assign tcnt_inc_s = tcnt_q + TMO_W'(1);

  always_comb begin
    state_d   = state_q;
    cs_d      = cs_q;
    hit_idx_d = hit_idx_q;
    dtack_n_d = dtack_n_q;
    berr_n_d  = berr_n_q;
    wcnt_d    = wcnt_q;
    ext_lat_d = ext_lat_q;
    tcnt_d    = tcnt_q;
    case (state_q)
      ST_IDLE: begin
        if (!bus.cpu_as_n) state_d = ST_DECODE;
      end
      ST_DECODE: begin
        if (bus.cpu_as_n) begin
          state_d = ST_IDLE;
        end else if (hit_s) begin
          cs_d          = '0;
          cs_d[hit_k_s] = 1'b1;
          hit_idx_d     = hit_k_s;
          wcnt_d        = wait_q[hit_k_s];
          ext_lat_d     = ext_q[hit_k_s];
          state_d       = ST_WAIT;
        end else begin
          tcnt_d  = '0;
          state_d = ST_TMO;
        end
      end
      ST_WAIT: begin
        if (bus.cpu_as_n) begin
          cs_d      = '0;
          hit_idx_d = 5'd0;
          wcnt_d    = '0;
          ext_lat_d = 1'b0;
          state_d   = ST_IDLE;
        end else if (wcnt_q != '0) begin
          wcnt_d = wcnt_q - WS_W'(1);
        end else if (!ext_lat_q || bus.ext_rdy) begin
          dtack_n_d = 1'b0;
          state_d   = ST_ACK;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_ACK: begin
        if (bus.cpu_as_n) begin
          cs_d      = '0;
          hit_idx_d = 5'd0;
          dtack_n_d = 1'b1;
          ext_lat_d = 1'b0;
          state_d   = ST_IDLE;
        end else begin
          state_d = ST_ACK;
        end
      end
      ST_TMO: begin
        if (bus.cpu_as_n) begin
          tcnt_d  = '0;
          state_d = ST_IDLE;
        end else begin
          tcnt_d = tcnt_inc_s;
          if (tcnt_inc_s == '1) begin
            berr_n_d = 1'b0;
            state_d  = ST_BERR;
          end else begin
            state_d = ST_TMO;
          end
        end
      end
      ST_BERR: begin
        if (bus.cpu_as_n) begin
          berr_n_d = 1'b1;
          tcnt_d   = '0;
          state_d  = ST_IDLE;
        end else begin
          state_d = ST_BERR;
        end
      end
      default: begin
        cs_d      = '0;
        hit_idx_d = 5'd0;
        dtack_n_d = 1'b1;
        berr_n_d  = 1'b1;
        wcnt_d    = '0;
        tcnt_d    = '0;
        ext_lat_d = 1'b0;
        state_d   = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      cs_q      <= '0;
      hit_idx_q <= 5'd0;
      dtack_n_q <= 1'b1;
      berr_n_q  <= 1'b1;
      wcnt_q    <= '0;
      ext_lat_q <= 1'b0;
      tcnt_q    <= '0;
    end else begin
      state_q   <= state_d;
      cs_q      <= cs_d;
      hit_idx_q <= hit_idx_d;
      dtack_n_q <= dtack_n_d;
      berr_n_q  <= berr_n_d;
      wcnt_q    <= wcnt_d;
      ext_lat_q <= ext_lat_d;
      tcnt_q    <= tcnt_d;
    end
  end

  assign bus.cs      = cs_q;
  assign bus.hit_idx = hit_idx_q;
  assign bus.dtack_n = dtack_n_q;
  assign bus.berr_n  = berr_n_q;
endmodule

// File: tb/tb_m68k_region_decoder.sv
// Self-checking bench for m68k_region_decoder: table of bus cycles with a scoreboard
// queue, plus hand sequences for abort, reset, same-cycle config and catch-all slots.
module tb_m68k_region_decoder;
  logic clk;
  logic reset_n;
  int   n_tests;
  int   n_fail;

  m68k_region_decoder_if #(.NREG(24), .AW(24), .WS_W(3)) bus ();

  m68k_region_decoder #(.NREG(24), .AW(24), .WS_W(3), .TMO_W(7)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [23:0] a;
    int          rdy;
    logic [23:0] cs;
    logic [4:0]  idx;
    int          lat;
    bit          berr;
  } vec_t;

  vec_t sb_q[$];
  vec_t tbl[6];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic cfg_write(input logic [4:0] idx, input logic [23:0] base, input logic [4:0] w,
                           input logic [2:0] ws, input logic ext, input logic en);
    @(negedge clk);
    bus.cfg_we = 1'b1; bus.cfg_idx = idx; bus.cfg_base = base;
    bus.cfg_width = w; bus.cfg_wait = ws; bus.cfg_ext = ext; bus.cfg_en = en;
    @(negedge clk);
    bus.cfg_we = 1'b0;
  endtask

  // Edge 0 is the first rising edge that sees AS low; latency is the edge index of the ack.
  task automatic bus_cycle(input vec_t v, input bit cfg_mid);
    vec_t e;
    int   edge_n;
    bit   done;
    @(negedge clk);
    bus.cpu_a = v.a; bus.cpu_as_n = 1'b0; bus.ext_rdy = (v.rdy < 0);
    sb_q.push_back(v);
    done = 1'b0; edge_n = 0;
    while (!done && edge_n < 300) begin
      @(posedge clk); #1;
      if (edge_n == 0) begin
        chk("cs_in_decode", {8'd0, bus.cs}, 32'd0);
        if (cfg_mid) bus.cfg_we = 1'b1;
      end
      if (edge_n == 1) bus.cfg_we = 1'b0;
      if (v.rdy >= 0 && edge_n == v.rdy) begin
        chk("dtack_while_rdy_low", {31'd0, bus.dtack_n}, 32'd1);
        bus.ext_rdy = 1'b1;
      end
      if (!bus.dtack_n || !bus.berr_n) begin
        done = 1'b1;
        e = sb_q.pop_front();
        chk("latency", edge_n, e.lat);
        chk("berr_kind", {31'd0, ~bus.berr_n}, {31'd0, e.berr});
        chk("cs", {8'd0, bus.cs}, {8'd0, e.cs});
        if (!e.berr) chk("hit_idx", {27'd0, bus.hit_idx}, {27'd0, e.idx});
        chk("cs_onehot0", {31'd0, $onehot0(bus.cs)}, 32'd1);
      end
      edge_n++;
    end
    if (!done) begin
      n_tests++; n_fail++;
      $display("FAIL timeout: no dtack/berr for addr 0x%0h within %0d edges", v.a, edge_n);
      e = sb_q.pop_front();
    end
    @(negedge clk);
    bus.cpu_as_n = 1'b1; bus.ext_rdy = 1'b1; bus.cfg_we = 1'b0;
    @(posedge clk); #1;
    chk("release_cs", {8'd0, bus.cs}, 32'd0);
    chk("release_dtack", {30'd0, bus.dtack_n, bus.berr_n}, 32'd3);
  endtask

  // Starts a cycle on slot 9 (wait 7) and stops after edge 3, leaving the DUT in WAIT.
  task automatic start_slow_cycle();
    @(negedge clk);
    bus.cpu_a = 24'hA00010; bus.cpu_as_n = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      if (k == 1) begin
        chk("slow_cs", {8'd0, bus.cs}, 32'h0000_0200);
        chk("slow_idx", {27'd0, bus.hit_idx}, 32'd9);
      end
    end
    chk("slow_no_dtack_yet", {31'd0, bus.dtack_n}, 32'd1);
  endtask

  initial begin
    n_tests = 0; n_fail = 0;
    reset_n = 1'b0;
    bus.cfg_we = 1'b0; bus.cfg_idx = 5'd0; bus.cfg_base = 24'h0; bus.cfg_width = 5'd0;
    bus.cfg_wait = 3'd0; bus.cfg_ext = 1'b0; bus.cfg_en = 1'b0;
    bus.cpu_a = 24'h0; bus.cpu_as_n = 1'b1; bus.ext_rdy = 1'b1;

    tbl[0] = '{24'h012345, -1, 24'h000001, 5'd0, 2,   1'b0};
    tbl[1] = '{24'h404010, -1, 24'h000008, 5'd3, 4,   1'b0};
    tbl[2] = '{24'h40F000, -1, 24'h000020, 5'd5, 3,   1'b0};
    tbl[3] = '{24'h812345, -1, 24'h000080, 5'd7, 2,   1'b0};
    tbl[4] = '{24'h8ABCDE, 5,  24'h000080, 5'd7, 6,   1'b0};
    tbl[5] = '{24'hF00000, -1, 24'h000000, 5'd0, 128, 1'b1};

    repeat (3) @(posedge clk);
    #1;
    chk("reset_cs", {8'd0, bus.cs}, 32'd0);
    chk("reset_idx", {27'd0, bus.hit_idx}, 32'd0);
    chk("reset_dtack_berr", {30'd0, bus.dtack_n, bus.berr_n}, 32'd3);
    @(negedge clk); reset_n = 1'b1;

    cfg_write(5'd0,  24'h000000, 5'd19, 3'd0, 1'b0, 1'b1);
    cfg_write(5'd3,  24'h404000, 5'd11, 3'd2, 1'b0, 1'b1);
    cfg_write(5'd5,  24'h400000, 5'd16, 3'd1, 1'b0, 1'b1);
    cfg_write(5'd7,  24'h800000, 5'd20, 3'd0, 1'b1, 1'b1);
    cfg_write(5'd9,  24'hA00000, 5'd20, 3'd7, 1'b0, 1'b1);
    cfg_write(5'd31, 24'hF00000, 5'd20, 3'd0, 1'b0, 1'b1);

    for (int i = 0; i < 6; i++) bus_cycle(tbl[i], 1'b0);

    // AS released in WAIT: everything idle on the next edge, then a normal cycle works.
    start_slow_cycle();
    @(negedge clk); bus.cpu_as_n = 1'b1;
    @(posedge clk); #1;
    chk("abort_cs", {8'd0, bus.cs}, 32'd0);
    chk("abort_dtack_berr", {30'd0, bus.dtack_n, bus.berr_n}, 32'd3);
    bus_cycle(tbl[1], 1'b0);

    // Slot 0 remapped during DECODE: the in-flight decode still sees the old window.
    bus.cfg_idx = 5'd0; bus.cfg_base = 24'h600000; bus.cfg_width = 5'd20;
    bus.cfg_wait = 3'd1; bus.cfg_ext = 1'b0; bus.cfg_en = 1'b1;
    bus_cycle(tbl[0], 1'b1);
    bus_cycle('{24'h600000, -1, 24'h000001, 5'd0, 3, 1'b0}, 1'b0);

    // Disabled slot ignored; full-width slot matches anything.
    cfg_write(5'd1,  24'hF00000, 5'd20, 3'd0, 1'b0, 1'b0);
    cfg_write(5'd20, 24'h123456, 5'd24, 3'd0, 1'b0, 1'b1);
    bus_cycle('{24'hF00000, -1, 24'h100000, 5'd20, 2, 1'b0}, 1'b0);

    // Reset mid-WAIT drops outputs without a clock edge and clears the table.
    start_slow_cycle();
    #2 reset_n = 1'b0;
    #1;
    chk("async_rst_cs", {8'd0, bus.cs}, 32'd0);
    chk("async_rst_dtack_berr", {30'd0, bus.dtack_n, bus.berr_n}, 32'd3);
    @(negedge clk); bus.cpu_as_n = 1'b1;
    @(negedge clk); reset_n = 1'b1;
    bus_cycle(tbl[5], 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
